int_ctrl: RTL

//  Interrupt controller: the requesting end of the processor's interrupt handshake.

---
 rtl/int_pkg.sv | 13 +
 rtl/int_prio_enc.sv | 25 ++
 rtl/int_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/int_pkg.sv
// Shared defaults and FSM state type for the interrupt controller.
package int_pkg;

    localparam int NUM_IRQ_DEF = 8;
    localparam int IDX_W_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } stateT;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder: index of the lowest set request bit plus an any flag.
module int_prio_enc
    import int_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches IRQ edges, requests the lowest pending unmasked line,
// holds it until fetch acks, then blocks until the handler's RTI retires.
module int_ctrl
    import int_pkg::*;
#(
    parameter int NUM_IRQ = NUM_IRQ_DEF,
    parameter int IDX_W   = IDX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               int_ack,
    input  logic               int_ret,
    output logic               int_req,
    output logic [IDX_W-1:0]   int_index,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending,
    output stateT              dbgState
);

    // Handshake: int_req stays high (index frozen) until int_ack; int_ack is only
    // honoured in REQ, int_ret only in SERVICE, and ack wins when both arrive in REQ.

    stateT              state;
    stateT              stateNext;
    logic [NUM_IRQ-1:0] irqPrev;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clrMask;
    logic [IDX_W-1:0]   encIdx;
    logic               encAny;
    logic               ackTake;

    assign rise     = irq & ~irqPrev;
    assign eligible = pending & ~irq_mask;

    int_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) uEnc (
        .req (eligible),
        .idx (encIdx),
        .any (encAny)
    );

    always_comb begin
        stateNext = state;
        ackTake   = 1'b0;
        case (state)
            IDLE: begin
                if (encAny) stateNext = REQ;
            end
            REQ: begin
                if (int_ack) begin
                    stateNext = SERVICE;
                    ackTake   = 1'b1;
                end
            end
            SERVICE: begin
                if (int_ret) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        clrMask = '0;
        if (ackTake) clrMask[int_index] = 1'b1;
    end

    // A fresh rise is ORed in after the clear, so a same-cycle re-rise survives the ack.
    always_ff @(posedge clk) begin
        irqPrev <= irq;
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            int_index <= '0;
        end else begin
            state   <= stateNext;
            pending <= (pending & ~clrMask) | rise;
            if (state == IDLE && encAny) int_index <= encIdx;
        end
    end

    assign int_req    = (state == REQ);
    assign in_service = (state == SERVICE);
    assign dbgState   = state;

endmodule
